// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, overlapping or
// non-overlapping matching and a saturating match counter.
module seq_detect_param #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               overlap_en,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);
  localparam logic [FW-1:0] FILL_THR = FW'(PAT_LEN - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               armed_q, armed_d;
  logic               detected_q, detected_d;
  logic [CNT_W-1:0]   match_count_q, match_count_d;
  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;

  logic [PAT_LEN-1:0] window;
  logic               match;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      armed_q       <= 1'b0;
      detected_q    <= 1'b0;
      match_count_q <= '0;
      pattern_q     <= '0;
      hist_q        <= '0;
      fill_q        <= '0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      detected_q    <= detected_d;
      match_count_q <= match_count_d;
      pattern_q     <= pattern_d;
      hist_q        <= hist_d;
      fill_q        <= fill_d;
    end
  end

  // Next-state, history shifting, match evaluation and counting.
  always_comb begin
    state_d       = state_q;
    detected_d    = 1'b0;
    match_count_d = match_count_q;
    pattern_d     = pattern_q;
    hist_d        = hist_q;
    fill_d        = fill_q;
    window        = {hist_q, din};
    match         = 1'b0;

    if (pat_load) begin
      // A load takes priority over any match completing on the same edge.
      state_d       = S_RUN;
      pattern_d     = pat_in;
      hist_d        = '0;
      fill_d        = '0;
      match_count_d = '0;
    end else if (state_q == S_RUN && din_valid) begin
      match = (fill_q >= FILL_THR) && (window == pattern_q);
      if (match) begin
        detected_d = 1'b1;
        if (match_count_q != '1) begin
          match_count_d = match_count_q + 1'b1;
        end
        if (overlap_en) begin
          hist_d = window[PAT_LEN-2:0];
          fill_d = FILL_MAX;
        end else begin
          hist_d = '0;
          fill_d = '0;
        end
      end else begin
        hist_d = window[PAT_LEN-2:0];
        fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
      end
    end

    armed_d = (state_d == S_RUN);
  end

  assign detected    = detected_q;
  assign match_count = match_count_q;
  assign armed       = armed_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the last valid bits.
module tb_seq_detect_param;

  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          din, din_valid, pat_load, overlap_en;
  logic [PL-1:0] pat_in;
  logic          detected, armed;
  logic [7:0]    match_count;
  logic          det2, arm2;
  logic [1:0]    cnt2;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_LEN(PL), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en),
    .detected(detected), .match_count(match_count), .armed(armed)
  );

  seq_detect_param #(.PAT_LEN(PL), .CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en),
    .detected(det2), .match_count(cnt2), .armed(arm2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  int pulses2  = 0;

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a queue of the most recent eligible valid bits.
  bit          m_armed, m_det, hit;
  int          m_cnt, m_cnt2;
  bit [PL-1:0] m_pat;
  bit          m_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_armed = 0; m_det = 0; m_cnt = 0; m_cnt2 = 0; m_pat = '0;
      m_q.delete();
    end else begin
      m_det = 0;
      if (pat_load) begin
        m_armed = 1; m_pat = pat_in; m_cnt = 0; m_cnt2 = 0;
        m_q.delete();
      end else if (m_armed && din_valid) begin
        m_q.push_back(din);
        if (m_q.size() > PL) void'(m_q.pop_front());
        if (m_q.size() == PL) begin
          hit = 1;
          for (int i = 0; i < PL; i++)
            if (m_q[i] != m_pat[PL-1-i]) hit = 0;
          if (hit) begin
            m_det = 1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
            if (!overlap_en) m_q.delete();
          end
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("detected", 32'(detected), 32'(m_det));
    check("match_count", 32'(match_count), 32'(m_cnt));
    check("armed", 32'(armed), 32'(m_armed));
    check("detected_w2", 32'(det2), 32'(m_det));
    check("match_count_w2", 32'(cnt2), 32'(m_cnt2));
    check("armed_w2", 32'(arm2), 32'(m_armed));
    pulses  += int'(detected);
    pulses2 += int'(det2);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    din_valid = 1'b0;
    din = 1'($urandom);
    step();
  endtask

  task automatic send_bit(input logic b);
    din_valid = 1'b1;
    din = b;
    step();
  endtask

  task automatic send_vec(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    din_valid = 1'b0;
  endtask

  // Load drives a valid '1' on the same edge to show it is ignored.
  task automatic load(input logic [PL-1:0] p, input logic ov);
    pat_load = 1'b1; pat_in = p; overlap_en = ov;
    din_valid = 1'b1; din = 1'b1;
    step();
    pat_load = 1'b0; din_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("async_rst_armed", 32'(armed), 32'd0);
    check("async_rst_cnt", 32'(match_count), 32'd0);
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; pat_load = 1'b0;
    pat_in = '0; overlap_en = 1'b0;
    #1;
    check("rst_detected", 32'(detected), 32'd0);
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    step(); step();
    reset = 1'b0;
    step();

    // No pattern loaded: stream is ignored.
    pulses = 0;
    send_vec(32'b1011, 4); idle();
    check("noload_pulses", 32'(pulses), 32'd0);
    check("noload_armed", 32'(armed), 32'd0);
    check("noload_count", 32'(match_count), 32'd0);

    // Overlapping: 1011011 matches twice.
    load(4'b1011, 1'b1);
    check("load_armed", 32'(armed), 32'd1);
    pulses = 0;
    send_vec(32'b1011011, 7); idle();
    check("ovl_pulses", 32'(pulses), 32'd2);
    check("ovl_count", 32'(match_count), 32'd2);

    // Non-overlapping: only the first match.
    load(4'b1011, 1'b0);
    pulses = 0;
    send_vec(32'b1011011, 7); idle();
    check("novl_pulses", 32'(pulses), 32'd1);
    check("novl_count", 32'(match_count), 32'd1);

    // Gapped bit is ignored.
    load(4'b1011, 1'b1);
    pulses = 0;
    send_vec(32'b10, 2);
    din_valid = 1'b0; din = 1'b1; step();
    send_vec(32'b11, 2); idle();
    check("gap_pulses", 32'(pulses), 32'd1);
    check("gap_count", 32'(match_count), 32'd1);

    // All-zero pattern, ten zeros: 7 matches, 2-bit counter saturates.
    load(4'b0000, 1'b1);
    pulses = 0; pulses2 = 0;
    send_vec(32'b0, 10); idle();
    check("zero_pulses", 32'(pulses), 32'd7);
    check("zero_pulses_w2", 32'(pulses2), 32'd7);
    check("zero_count", 32'(match_count), 32'd7);
    check("zero_count_w2", 32'(cnt2), 32'd3);

    // 8-bit counter saturation.
    load(4'b0000, 1'b1);
    for (int i = 0; i < 300; i++) send_bit(1'b0);
    idle();
    check("sat_count", 32'(match_count), 32'd255);

    // Reset mid-stream discards history and disarms.
    load(4'b1011, 1'b1);
    send_vec(32'b101, 3);
    do_reset();
    check("midrst_armed", 32'(armed), 32'd0);
    pulses = 0;
    send_bit(1'b1); idle();
    check("midrst_pulses", 32'(pulses), 32'd0);

    // Reload mid-stream; load edge carries the would-be completing bit.
    load(4'b1011, 1'b1);
    send_vec(32'b101, 3);
    pulses = 0;
    load(4'b1011, 1'b1);
    check("reload_count", 32'(match_count), 32'd0);
    send_bit(1'b1); idle();
    check("reload_pulses", 32'(pulses), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(999) < 3) begin
        do_reset();
      end else if ($urandom_range(99) < 2) begin
        load(PL'($urandom), 1'($urandom));
      end else begin
        overlap_en = ($urandom_range(9) < 6);
        din_valid  = ($urandom_range(9) < 8);
        din        = 1'($urandom);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_LEN, 4, pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, 8, width of the match counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 din  input  1  serial data bit.
REQ-006 din_valid  input  1  din sampled only when high.
REQ-007 pat_load  input  1  load pat_in as new pattern; arms detector.
REQ-008 pat_in  input  PAT_LEN  pattern; pat_in[PAT_LEN-1] is first bit expected on the line.
REQ-009 overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 detected  output  1  registered one-cycle pulse per match.
REQ-011 match_count  output  CNT_W  saturating count of matches since last load or reset.
REQ-012 armed  output  1  high when a pattern is loaded and detection is active.

Function
REQ-013 State machine SHALL have two states: IDLE (armed=0, no detection) and RUN (armed=1); armed SHALL be a registered decode of the state.
REQ-014 IDLE -> RUN on pat_load; RUN -> RUN on pat_load (reload); no other transition except reset -> IDLE.
REQ-015 pat_load SHALL capture pat_in into pattern register, clear history register, fill counter and match_count, force detected=0; din on that cycle SHALL be ignored.
REQ-016 In RUN with din_valid=1, history SHALL shift: hist <= {hist[PAT_LEN-2:0], din}; fill counter SHALL increment, saturating at PAT_LEN.
REQ-017 din_valid=0 SHALL leave hist, fill and match_count unchanged and drive detected=0 next cycle.
REQ-018 Match SHALL be: state RUN, din_valid=1, fill >= PAT_LEN-1 before the edge, and {hist[PAT_LEN-2:0], din} == pattern register.
REQ-019 On a match, detected SHALL be 1 for exactly the cycle following the edge that sampled the final pattern bit (latency 1 clock); otherwise 0.
REQ-020 On a match with overlap_en=1, fill SHALL remain saturated so a pattern suffix can begin the next match.
REQ-021 On a match with overlap_en=0, hist and fill SHALL be cleared to 0; the completing bit SHALL NOT count toward the next match.
REQ-022 overlap_en SHALL be sampled only on the match edge; changes between matches have no other effect.
REQ-023 match_count SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrap.
REQ-024 pat_load and a would-be match on the same edge: load wins, no detection, no count.
REQ-025 In IDLE, din/din_valid SHALL have no effect; detected stays 0.

Reset
REQ-026 reset=1 SHALL immediately force state=IDLE, armed=0, detected=0, match_count=0, pattern register=0, hist=0, fill=0, independent of clk.
REQ-027 Reset asserted mid-stream SHALL discard partial history; after release a pat_load is required before any detection.

Verification
REQ-028 Reset, no pat_load, stream 1,0,1,1 valid -> detected never high, armed=0, match_count=0.
REQ-029 PAT_LEN=4, load 1011, overlap_en=1, stream 1,0,1,1,0,1,1 -> detected pulses after bits 4 and 7, match_count=2.
REQ-030 Same as REQ-029 with overlap_en=0 -> detected pulse after bit 4 only, match_count=1.
REQ-031 Load 1011, stream 1,0,(din=1 with din_valid=0),1,1 -> single pulse after last bit; gapped bit ignored; match_count=1.
REQ-032 CNT_W=2, load 0000, overlap_en=1, ten valid zeros -> 7 detected pulses (bits 4..10), match_count saturates at 3.
REQ-033 Load 1011, stream 1,0,1 then reset pulse (or pat_load 1011), then 1 -> no detection; after reset armed=0; after reload match_count=0.
